// File: rtl/conv_accumulator_pkg.sv
// Shared processing-domain definitions for the D3 multiply stage and the
// convolution accumulator.
package conv_accumulator_pkg;

    localparam int D3_MULT_N = 25;
    localparam int D3_PROD_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/conv_round_sat.sv
// Round-half-up, right shift and unsigned saturation of one accumulated
// sum, registered once.
module conv_round_sat #(
    parameter int ACC_W = 37,
    parameter int SHIFT = 5,
    parameter int OUT_W = 32
) (
    input  logic             clkf,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] sum_o,
    output logic             sat_o
);

    localparam int RW = ACC_W + 1;

    logic [RW-1:0]    half;
    logic [RW-1:0]    r;
    logic             ovf;
    logic [OUT_W-1:0] sum_d;
    logic [OUT_W-1:0] sum_q;
    logic             sat_q;

    generate
        if (SHIFT > 0) begin : g_rnd
            assign half = RW'(1) << (SHIFT - 1);
        end else begin : g_nornd
            assign half = '0;
        end
    endgenerate

    // One guard bit above the accumulator so the rounding add cannot wrap.
    assign r     = ({1'b0, acc_i} + half) >> SHIFT;
    assign ovf   = |r[RW-1:OUT_W];
    assign sum_d = ovf ? '1 : r[OUT_W-1:0];

    always_ff @(posedge clkf) begin
        if (rst) begin
            sum_q <= '0;
            sat_q <= 1'b0;
        end else if (valid_i) begin
            sum_q <= sum_d;
            sat_q <= ovf;
        end
    end

    assign sum_o = sum_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/conv_accumulator.sv
// Per-window accumulation of A/B product terms with a shared control path
// feeding two independent round/saturate output stages.
module conv_accumulator
    import conv_accumulator_pkg::*;
#(
    parameter int MULT_N = D3_MULT_N,
    parameter int IN_W   = D3_PROD_W,
    parameter int SHIFT  = 5,
    parameter int OUT_W  = 32,
    localparam int ACC_W = IN_W + $clog2(MULT_N),
    localparam int CNT_W = $clog2(MULT_N + 1)
) (
    input  logic             clkf,
    input  logic             rst,
    input  logic             prod_valid,
    input  logic             prod_first,
    input  logic [IN_W-1:0]  DATA_IN_A,
    input  logic [IN_W-1:0]  DATA_IN_B,
    output logic [OUT_W-1:0] SUM_A,
    output logic [OUT_W-1:0] SUM_B,
    output logic             sum_valid,
    output logic             sat_a,
    output logic             sat_b,
    output logic             win_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_a_q, acc_a_d;
    logic [ACC_W-1:0] acc_b_q, acc_b_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             sv_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (prod_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (prod_first) begin
                        acc_a_d = ACC_W'(DATA_IN_A);
                        acc_b_d = ACC_W'(DATA_IN_B);
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ACCUM: begin
                    if (prod_first) begin
                        // Aborted window: this term opens the next one.
                        err_d   = 1'b1;
                        acc_a_d = ACC_W'(DATA_IN_A);
                        acc_b_d = ACC_W'(DATA_IN_B);
                        cnt_d   = CNT_W'(1);
                    end else begin
                        acc_a_d = acc_a_q + ACC_W'(DATA_IN_A);
                        acc_b_d = acc_b_q + ACC_W'(DATA_IN_B);
                        if (cnt_q == CNT_W'(MULT_N - 1)) begin
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkf) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sv_q    <= done_q;
        end
    end

    // Output stage samples the finished sum before the next window overwrites it.
    conv_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_rs_a (
        .clkf    (clkf),
        .rst     (rst),
        .valid_i (done_q),
        .acc_i   (acc_a_q),
        .sum_o   (SUM_A),
        .sat_o   (sat_a)
    );

    conv_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_rs_b (
        .clkf    (clkf),
        .rst     (rst),
        .valid_i (done_q),
        .acc_i   (acc_b_q),
        .sum_o   (SUM_B),
        .sat_o   (sat_b)
    );

    assign sum_valid = sv_q;
    assign win_err   = err_q;
    assign busy      = (state_q == ACCUM);

endmodule
